// File: rtl/count_seq_pkg.sv
// -----------------------------------------------------------------------------
// count_seq_pkg
//   Shared definitions for the count sequencer slice.
//   - cmd_op_e : command opcodes carried on cmd_op
//   - state_e  : sequencer FSM states
//   - state_is_busy() : true while a count is in progress (RUN or PAUSE)
// -----------------------------------------------------------------------------
package count_seq_pkg;

    typedef enum logic [1:0] {
        OP_START  = 2'b00,
        OP_PAUSE  = 2'b01,
        OP_RESUME = 2'b10,
        OP_ABORT  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // A count is "in progress" while running or paused; a new START must wait.
    function automatic logic state_is_busy(input state_e s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// -----------------------------------------------------------------------------
// count_prescaler
//   Programmable tick generator. A down-counter loaded with div produces a
//   single-clock tick every div+1 enabled clocks (div=0 -> tick every clock).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en         : count enable; phase holds while low
//     clr        : reload phase from div (highest priority, suppresses tick)
//     div        : divisor, reloaded on clr and on every tick
//     tick       : one-clock pulse when the phase reaches zero while enabled
// -----------------------------------------------------------------------------
module count_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] phase_q;

    // Tick is decoded from the registered phase so the owner sees it in the
    // same cycle it acts on it; a clear in that cycle cancels it.
    assign tick = en && !clr && (phase_q == '0);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (clr) begin
            phase_q <= div;
        end else if (en) begin
            if (phase_q == '0) begin
                phase_q <= div;
            end else begin
                phase_q <= phase_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// -----------------------------------------------------------------------------
// count_seq_ctrl
//   Command-driven sequencer for a WIDTH-bit event counter. Commands arrive on
//   a valid/ready port and start, pause, resume or abort counting. Count ticks
//   are paced by count_prescaler; terminal count is flagged by tc_pulse and,
//   in one-shot mode, by the done level.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     cmd_valid     : command present
//     cmd_ready     : low only while a START is presented during RUN/PAUSE
//     cmd_op        : 00 START, 01 PAUSE, 10 RESUME, 11 ABORT
//     cmd_target    : terminal value (START only)
//     cmd_div       : tick every cmd_div+1 clocks (START only)
//     cmd_periodic  : 1 auto-wrap at target, 0 one-shot (START only)
//     cnt_q         : current count
//     busy          : RUN or PAUSE
//     paused        : PAUSE
//     tc_pulse      : one clock when cnt_q becomes target
//     done          : one-shot count completed (DONE state)
// -----------------------------------------------------------------------------
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_target,
    input  logic [PRESCALE_W-1:0] cmd_div,
    input  logic                  cmd_periodic,
    output logic [WIDTH-1:0]      cnt_q,
    output logic                  busy,
    output logic                  paused,
    output logic                  tc_pulse,
    output logic                  done
);

    state_e                state_q;
    logic [WIDTH-1:0]      target_q;
    logic [PRESCALE_W-1:0] div_q;
    logic                  periodic_q;

    cmd_op_e               op;
    logic                  cmd_fire;
    logic                  start_fire;
    logic                  pause_fire;
    logic                  resume_fire;
    logic                  abort_fire;

    logic                  ps_en;
    logic                  ps_clr;
    logic [PRESCALE_W-1:0] ps_div;
    logic                  tick;

    logic [WIDTH-1:0]      cnt_next;
    logic                  hit_target;
    logic                  oneshot_end;

    // -------------------------------------------------------------------------
    // Command decode and tick arithmetic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        op          = cmd_op_e'(cmd_op);
        cmd_ready   = 1'b1;
        cmd_fire    = 1'b0;
        start_fire  = 1'b0;
        pause_fire  = 1'b0;
        resume_fire = 1'b0;
        abort_fire  = 1'b0;

        // Only a START against an active count is back-pressured; all other
        // out-of-place commands are taken and ignored by the FSM.
        if (cmd_valid && (op == OP_START) && state_is_busy(state_q)) begin
            cmd_ready = 1'b0;
        end

        cmd_fire = cmd_valid && cmd_ready;
        if (cmd_fire) begin
            unique case (op)
                OP_START:  start_fire  = 1'b1;
                OP_PAUSE:  pause_fire  = 1'b1;
                OP_RESUME: resume_fire = 1'b1;
                OP_ABORT:  abort_fire  = 1'b1;
            endcase
        end

        // The prescaler starts a fresh phase on START (using the new divisor
        // before it is latched) and on ABORT; it only advances while running.
        ps_clr = start_fire || abort_fire;
        ps_div = start_fire ? cmd_div : div_q;
        ps_en  = (state_q == ST_RUN);

        // Periodic wrap at target. With target=0 the natural modulo wrap is
        // the terminal event, so the explicit wrap is skipped and the count
        // still leaves zero on the first tick.
        if (periodic_q && (target_q != '0) && (cnt_q == target_q)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_q + 1'b1;
        end

        hit_target  = (cnt_next == target_q);
        oneshot_end = tick && hit_target && !periodic_q;
    end

    count_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ps_en),
        .clr   (ps_clr),
        .div   (ps_div),
        .tick  (tick)
    );

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered status outputs
    // -------------------------------------------------------------------------
    // NOTE: the latched START parameters are ordinary control flops, so they
    // are reset along with the FSM rather than left to power-up values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            div_q      <= '0;
            periodic_q <= 1'b0;
            busy       <= 1'b0;
            paused     <= 1'b0;
            tc_pulse   <= 1'b0;
            done       <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;

            if (abort_fire) begin
                // ABORT overrides any tick landing on the same edge.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy    <= 1'b0;
                paused  <= 1'b0;
                done    <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start_fire) begin
                            state_q    <= ST_RUN;
                            cnt_q      <= '0;
                            target_q   <= cmd_target;
                            div_q      <= cmd_div;
                            periodic_q <= cmd_periodic;
                            busy       <= 1'b1;
                            paused     <= 1'b0;
                            done       <= 1'b0;
                        end
                    end

                    ST_RUN: begin
                        if (tick) begin
                            cnt_q    <= cnt_next;
                            tc_pulse <= hit_target;
                        end
                        // A one-shot completion outranks a PAUSE on the same edge.
                        if (oneshot_end) begin
                            state_q <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (pause_fire) begin
                            state_q <= ST_PAUSE;
                            paused  <= 1'b1;
                        end
                    end

                    ST_PAUSE: begin
                        if (resume_fire) begin
                            state_q <= ST_RUN;
                            paused  <= 1'b0;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_seq_ctrl
//   Directed bench for count_seq_ctrl (WIDTH=4, PRESCALE_W=8). Stimulus pushes
//   hand-computed count events {cnt, tc, done, edge index} into a queue; a
//   monitor pops one whenever cnt_q changes or tc_pulse is high and compares.
// -----------------------------------------------------------------------------
module tb_count_seq_ctrl;
    import count_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_target;
    logic [7:0] cmd_div;
    logic       cmd_periodic;
    logic [3:0] cnt_q;
    logic       busy;
    logic       paused;
    logic       tc_pulse;
    logic       done;

    count_seq_ctrl #(
        .WIDTH      (4),
        .PRESCALE_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_target   (cmd_target),
        .cmd_div      (cmd_div),
        .cmd_periodic (cmd_periodic),
        .cnt_q        (cnt_q),
        .busy         (busy),
        .paused       (paused),
        .tc_pulse     (tc_pulse),
        .done         (done)
    );

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        logic       done;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [3:0] prev_cnt = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: value of cyc just after a posedge is that edge's number.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input logic [3:0] c, input logic t, input logic d, input int n);
        ev_t e;
        e.cnt  = c;
        e.tc   = t;
        e.done = d;
        e.cyc  = n;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_cnt = cnt_q;
        end else if ((cnt_q !== prev_cnt) || tc_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: cnt=%0d tc=%0d edge=%0d", cnt_q, tc_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ev_cnt",  32'(cnt_q),    32'(e.cnt));
                check("ev_tc",   32'(tc_pulse), 32'(e.tc));
                check("ev_done", 32'(done),     32'(e.done));
                check("ev_edge", cyc,           e.cyc);
            end
            prev_cnt = cnt_q;
        end
    end

    // Issue one command from a falling edge; returns the accepting edge index.
    task automatic send(input cmd_op_e op, input logic [3:0] tgt, input logic [7:0] dv,
                        input logic per, output int acc);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_target   = tgt;
        cmd_div      = dv;
        cmd_periodic = per;
        acc          = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op=%0d never accepted", op);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a;

        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_target   = '0;
        cmd_div      = '0;
        cmd_periodic = 1'b0;

        // ---------------- reset state ----------------
        #1;
        check("rst_cnt",    32'(cnt_q),     0);
        check("rst_busy",   32'(busy),      0);
        check("rst_done",   32'(done),      0);
        check("rst_ready",  32'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- one-shot target=3 div=1 ----------------
        send(OP_START, 4'd3, 8'd1, 1'b0, n);
        push_ev(4'd1, 1'b0, 1'b0, n + 2);
        push_ev(4'd2, 1'b0, 1'b0, n + 4);
        push_ev(4'd3, 1'b1, 1'b1, n + 6);
        @(negedge clk);
        check("os_busy", 32'(busy), 1);
        repeat (8) @(negedge clk);
        check("os_done", 32'(done),  1);
        check("os_idle", 32'(busy),  0);
        check("os_hold", 32'(cnt_q), 3);

        // ---------------- periodic target=2 div=0, START from DONE ----------------
        send(OP_START, 4'd2, 8'd0, 1'b1, n);
        push_ev(4'd0, 1'b0, 1'b0, n);
        push_ev(4'd1, 1'b0, 1'b0, n + 1);
        push_ev(4'd2, 1'b1, 1'b0, n + 2);
        push_ev(4'd0, 1'b0, 1'b0, n + 3);
        push_ev(4'd1, 1'b0, 1'b0, n + 4);
        // ABORT lands on the edge where the count would reach target again.
        push_ev(4'd0, 1'b0, 1'b0, n + 5);
        repeat (5) @(negedge clk);
        send(OP_ABORT, 4'd0, 8'd0, 1'b0, a);
        check("per_abort_edge", a, n + 5);
        @(negedge clk);
        check("per_abort_busy", 32'(busy), 0);

        // ---------------- one-shot ABORT on terminal tick ----------------
        send(OP_START, 4'd2, 8'd0, 1'b0, n);
        push_ev(4'd1, 1'b0, 1'b0, n + 1);
        push_ev(4'd0, 1'b0, 1'b0, n + 2);
        repeat (2) @(negedge clk);
        send(OP_ABORT, 4'd0, 8'd0, 1'b0, a);
        check("col_abort_edge", a, n + 2);
        @(negedge clk);
        check("col_done", 32'(done), 0);
        check("col_busy", 32'(busy), 0);

        // ---------------- pause mid-phase, div=3 ----------------
        send(OP_START, 4'd10, 8'd3, 1'b0, n);
        for (int i = 1; i <= 5; i++) push_ev(4'(i), 1'b0, 1'b0, n + 4 * i);
        push_ev(4'd6, 1'b0, 1'b0, n + 35);
        push_ev(4'd0, 1'b0, 1'b0, n + 36);
        repeat (22) @(negedge clk);
        send(OP_PAUSE, 4'd0, 8'd0, 1'b0, a);
        check("pause_edge", a, n + 22);
        @(negedge clk);
        check("pause_paused", 32'(paused), 1);
        check("pause_busy",   32'(busy),   1);
        check("pause_cnt",    32'(cnt_q),  5);
        repeat (10) @(negedge clk);
        check("pause_held", 32'(cnt_q), 5);
        send(OP_RESUME, 4'd0, 8'd0, 1'b0, a);
        check("resume_edge", a, n + 33);
        @(negedge clk);
        check("resume_paused", 32'(paused), 0);
        repeat (2) @(negedge clk);
        send(OP_ABORT, 4'd0, 8'd0, 1'b0, a);

        // ---------------- illegal PAUSE in IDLE is accepted and ignored ----------------
        @(negedge clk);
        send(OP_PAUSE, 4'd0, 8'd0, 1'b0, a);
        @(negedge clk);
        check("ill_paused", 32'(paused), 0);
        check("ill_busy",   32'(busy),   0);

        // ---------------- backpressure ----------------
        send(OP_START, 4'd9, 8'd255, 1'b0, n);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        send(OP_ABORT, 4'd0, 8'd0, 1'b0, a);
        @(negedge clk);
        check("bp_abort_busy", 32'(busy), 0);
        send(OP_START, 4'd1, 8'd0, 1'b0, n);
        push_ev(4'd1, 1'b1, 1'b1, n + 1);
        repeat (3) @(negedge clk);
        check("bp_done", 32'(done), 1);

        // ---------------- target=0 one-shot: terminal after 16 ticks ----------------
        send(OP_START, 4'd0, 8'd0, 1'b0, n);
        push_ev(4'd0, 1'b0, 1'b0, n);
        for (int i = 1; i <= 16; i++) push_ev(4'(i), i == 16, i == 16, n + i);
        repeat (20) @(negedge clk);
        check("t0_done", 32'(done),  1);
        check("t0_cnt",  32'(cnt_q), 0);

        // ---------------- async reset mid-RUN ----------------
        send(OP_START, 4'd15, 8'd0, 1'b1, n);
        push_ev(4'd1, 1'b0, 1'b0, n + 1);
        push_ev(4'd2, 1'b0, 1'b0, n + 2);
        push_ev(4'd3, 1'b0, 1'b0, n + 3);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_cnt",    32'(cnt_q),     0);
        check("mrst_busy",   32'(busy),      0);
        check("mrst_paused", 32'(paused),    0);
        check("mrst_done",   32'(done),      0);
        check("mrst_tc",     32'(tc_pulse),  0);
        check("mrst_ready",  32'(cmd_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_cnt", 32'(cnt_q), 0);
        check("post_rst_tc",  32'(tc_pulse), 0);
        check("sb_drained",   exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
